// File: rtl/ch_measure_ctrl.sv
// Equivalent-time sampling sequencer: for each delay code, ramp the DAC threshold until the comparator drops, then emit one point.
// Optional macro CH_MEASURE_SYNC_EN: 2-flop synchronizers on cmp_out_i and threshold_rdy_i.
module ch_measure_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int TW            = 10,
    parameter int VW            = 16
) (
    input  logic          clk_i,
    input  logic          arst_i,
    input  logic          run_i,
    input  logic [VW-1:0] threshold_delta_i,
    input  logic [TW-1:0] d_code_delta_i,
    output logic [VW-1:0] threshold_o,
    output logic          threshold_wre_o,
    input  logic          threshold_rdy_i,
    input  logic          cmp_out_i,
    output logic          stb_req_o,
    input  logic          stb_valid_i,
    output logic [TW-1:0] d_code_o,
    output logic          point_rdy_o,
    output logic [VW-1:0] point_v_o,
    output logic [TW-1:0] point_t_o
);

    localparam int CW = 16;
`ifdef CH_MEASURE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam logic [CW-1:0] LO_TIMEOUT  = 16'd15;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES + SYNC_LAT - 1);
    localparam logic [TW-1:0] CODE_MAX    = {TW{1'b1}};

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR      = 4'd1,
        ST_WAIT_LO = 4'd2,
        ST_WAIT_HI = 4'd3,
        ST_REQ     = 4'd4,
        ST_SETTLE  = 4'd5,
        ST_SAMPLE  = 4'd6,
        ST_EMIT    = 4'd7,
        ST_NEXT    = 4'd8,
        ST_DONE    = 4'd9
    } state_t;

    // A zero step would stall the search, so it is promoted to one.
    function automatic logic [VW-1:0] thr_step(input logic [VW-1:0] d);
        thr_step = (d == {VW{1'b0}}) ? {{(VW-1){1'b0}}, 1'b1} : d;
    endfunction

    function automatic logic [TW-1:0] next_code(input logic [TW-1:0] c, input logic [TW-1:0] d);
        logic [TW:0]   sum;
        logic [TW-1:0] dd;
        dd        = (d == {TW{1'b0}}) ? {{(TW-1){1'b0}}, 1'b1} : d;
        sum       = {1'b0, c} + {1'b0, dd};
        next_code = sum[TW] ? CODE_MAX : sum[TW-1:0];
    endfunction

    state_t        state_r, state_n;
    logic [VW-1:0] thr_r, thr_n;
    logic [TW-1:0] code_r, code_n;
    logic [CW-1:0] cnt_r, cnt_n;
    logic [VW-1:0] pv_r, pv_n;
    logic [TW-1:0] pt_r, pt_n;
    logic          wre_r, req_r, prdy_r;
    logic [VW:0]   thr_sum_s;
    logic          cmp_s, rdy_s;

`ifdef CH_MEASURE_SYNC_EN
    logic [1:0] cmp_sync_r, rdy_sync_r;

    // Two-flop synchronizers for the asynchronous comparator and DAC-ready inputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cmp_sync_r <= 2'b00;
            rdy_sync_r <= 2'b00;
        end else begin
            cmp_sync_r <= {cmp_sync_r[0], cmp_out_i};
            rdy_sync_r <= {rdy_sync_r[0], threshold_rdy_i};
        end
    end
    assign cmp_s = cmp_sync_r[1];
    assign rdy_s = rdy_sync_r[1];
`else
    assign cmp_s = cmp_out_i;
    assign rdy_s = threshold_rdy_i;
`endif

    // Next-state and next-value logic; dropping run_i aborts every active state.
    always_comb begin
        state_n   = state_r;
        thr_n     = thr_r;
        code_n    = code_r;
        cnt_n     = cnt_r;
        pv_n      = pv_r;
        pt_n      = pt_r;
        thr_sum_s = {1'b0, thr_r} + {1'b0, thr_step(threshold_delta_i)};
        if (!run_i && (state_r != ST_IDLE) && (state_r != ST_DONE)) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run_i) begin
                        code_n  = {TW{1'b0}};
                        thr_n   = {VW{1'b0}};
                        state_n = ST_WR;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_WR: begin
                    cnt_n   = {CW{1'b0}};
                    state_n = ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (!rdy_s || (cnt_r == LO_TIMEOUT)) begin
                        state_n = ST_WAIT_HI;
                    end else begin
                        cnt_n = cnt_r + 16'd1;
                    end
                end
                ST_WAIT_HI: begin
                    if (rdy_s) begin
                        state_n = ST_REQ;
                    end else begin
                        state_n = ST_WAIT_HI;
                    end
                end
                ST_REQ: begin
                    if (stb_valid_i) begin
                        cnt_n   = {CW{1'b0}};
                        state_n = ST_SETTLE;
                    end else begin
                        state_n = ST_REQ;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        state_n = ST_SAMPLE;
                    end else begin
                        cnt_n = cnt_r + 16'd1;
                    end
                end
                ST_SAMPLE: begin
                    // Bit VW of the sum flags overflow: keep the last in-range threshold.
                    if (cmp_s && !thr_sum_s[VW]) begin
                        thr_n   = thr_sum_s[VW-1:0];
                        state_n = ST_WR;
                    end else begin
                        pv_n    = thr_r;
                        pt_n    = code_r;
                        state_n = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    state_n = ST_NEXT;
                end
                ST_NEXT: begin
                    if (code_r == CODE_MAX) begin
                        state_n = ST_DONE;
                    end else begin
                        code_n  = next_code(code_r, d_code_delta_i);
                        thr_n   = {VW{1'b0}};
                        state_n = ST_WR;
                    end
                end
                ST_DONE: begin
                    if (!run_i) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; strobe/write/point pulses track the state being entered.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_r <= ST_IDLE;
            thr_r   <= {VW{1'b0}};
            code_r  <= {TW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            pv_r    <= {VW{1'b0}};
            pt_r    <= {TW{1'b0}};
            wre_r   <= 1'b0;
            req_r   <= 1'b0;
            prdy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            thr_r   <= thr_n;
            code_r  <= code_n;
            cnt_r   <= cnt_n;
            pv_r    <= pv_n;
            pt_r    <= pt_n;
            wre_r   <= (state_n == ST_WR);
            req_r   <= (state_n == ST_REQ);
            prdy_r  <= (state_n == ST_EMIT);
        end
    end

    assign threshold_o     = thr_r;
    assign threshold_wre_o = wre_r;
    assign stb_req_o       = req_r;
    assign d_code_o        = code_r;
    assign point_rdy_o     = prdy_r;
    assign point_v_o       = pv_r;
    assign point_t_o       = pt_r;

endmodule

// File: tb/tb_ch_measure_ctrl.sv
// Self-checking bench for ch_measure_ctrl: DAC, comparator and strobe-generator models plus a point-list reference model.
module tb_ch_measure_ctrl;

    logic        clk = 1'b0;
    logic        arst, run, rdy, stb_valid, wre, stb_req, prdy;
    logic [15:0] td, thr, pv;
    logic [9:0]  dd, dcode, pt;
    logic        cmp;
    logic [15:0] sig_tab [0:1023];

    typedef struct {
        logic [15:0] v;
        logic [9:0]  t;
    } pt_t;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] tdel;
        logic [9:0]  ddel;
        int          lat;
        bit          hold;
        int          exp_n;
        logic [15:0] exp_v;
    } vec_t;

    pt_t  got_q[$];
    pt_t  exp_q[$];
    vec_t vecs[4];
    int   total = 0, bad = 0;
    int   dac_lat = 2, dac_cnt = 0, stb_wait = 0;
    bit   dac_hold = 1'b0, dac_rand = 1'b0, spurious = 1'b0;
    int   wre_cnt = 0, rdy_wide_err = 0, wre_wide_err = 0, early_req_err = 0;
    bit   prev_prdy = 1'b0, prev_wre = 1'b0, prev_req = 1'b0;

    always #5 clk = ~clk;

    ch_measure_ctrl dut (
        .clk_i(clk), .arst_i(arst), .run_i(run),
        .threshold_delta_i(td), .d_code_delta_i(dd),
        .threshold_o(thr), .threshold_wre_o(wre), .threshold_rdy_i(rdy),
        .cmp_out_i(cmp), .stb_req_o(stb_req), .stb_valid_i(stb_valid),
        .d_code_o(dcode), .point_rdy_o(prdy), .point_v_o(pv), .point_t_o(pt)
    );

    // Waveform is a per-delay-code level; the comparator reports signal >= threshold.
    assign cmp = (sig_tab[dcode] >= thr);

    // DAC model: ready drops on a write and returns after the configured latency.
    always @(negedge clk) begin
        if (arst) begin
            rdy     = 1'b1;
            dac_cnt = 0;
        end else if (wre && !dac_hold) begin
            rdy     = 1'b0;
            dac_cnt = dac_rand ? $urandom_range(2, dac_lat) : dac_lat;
        end else if (dac_cnt > 0) begin
            dac_cnt--;
            if (dac_cnt == 0) rdy = 1'b1;
        end
    end

    // Strobe generator model: acknowledges a request after 0..3 cycles, optional stray pulses.
    always @(negedge clk) begin
        if (arst || stb_valid) begin
            stb_valid = 1'b0;
        end else if (stb_req) begin
            if (stb_wait > 0) stb_wait--;
            else begin
                stb_valid = 1'b1;
                stb_wait  = $urandom_range(0, 3);
            end
        end else if (spurious && ($urandom_range(0, 7) == 0)) begin
            stb_valid = 1'b1;
        end
    end

    // Output monitor: collects points and flags protocol violations.
    always @(posedge clk) begin
        #1;
        if (!arst) begin
            if (prdy) begin
                got_q.push_back('{pv, pt});
                if (prev_prdy) rdy_wide_err++;
            end
            if (wre) begin
                wre_cnt++;
                if (prev_wre) wre_wide_err++;
            end
            if (stb_req && !prev_req && !rdy) early_req_err++;
        end
        prev_prdy = prdy;
        prev_wre  = wre;
        prev_req  = stb_req;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: point list derived directly from the sweep rules.
    task automatic build_model(input logic [15:0] tdel, input logic [9:0] ddel, output int n_wr);
        int  step, dstep, d, v;
        bit  last;
        pt_t p;
        step  = (tdel == 16'd0) ? 1 : int'(tdel);
        dstep = (ddel == 10'd0) ? 1 : int'(ddel);
        exp_q.delete();
        n_wr = 0;
        d    = 0;
        last = 1'b0;
        while (!last) begin
            v = 0;
            n_wr++;
            while ((int'(sig_tab[d]) >= v) && (v + step <= 65535)) begin
                v += step;
                n_wr++;
            end
            p.v = v[15:0];
            p.t = d[9:0];
            exp_q.push_back(p);
            if (d == 1023) last = 1'b1;
            else d = (d + dstep > 1023) ? 1023 : d + dstep;
        end
    endtask

    task automatic fill_sig(input logic [15:0] val);
        for (int i = 0; i < 1024; i++) sig_tab[i] = val;
    endtask

    task automatic run_sweep(input string name, input logic [15:0] tdel, input logic [9:0] ddel,
                             input int lat, input bit hold, input bit rnd);
        int n_wr, cyc, n;
        build_model(tdel, ddel, n_wr);
        got_q.delete();
        wre_cnt = 0; rdy_wide_err = 0; wre_wide_err = 0; early_req_err = 0;
        dac_lat = lat; dac_hold = hold; dac_rand = rnd; spurious = rnd;
        @(negedge clk);
        td = tdel; dd = ddel; run = 1'b1;
        cyc = 0;
        while (!((got_q.size() > 0) && (got_q[$].t == 10'd1023)) && (cyc < 60000)) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " finished"}, (cyc < 60000), 64'd1);
        repeat (6) @(negedge clk);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        check({name, " npts"}, got_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s v[%0d]", name, i), got_q[i].v, exp_q[i].v);
            check($sformatf("%s t[%0d]", name, i), got_q[i].t, exp_q[i].t);
        end
        check({name, " wre count"}, wre_cnt, n_wr);
        check({name, " wre width"}, wre_wide_err, 0);
        check({name, " rdy width"}, rdy_wide_err, 0);
        check({name, " req before dac rdy"}, early_req_err, 0);
        check({name, " done code"}, dcode, 10'd1023);
        check({name, " done thr hold"}, thr, exp_q[$].v);
        check({name, " done no req"}, {stb_req, wre, prdy}, 3'b000);
        run = 1'b0; spurious = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_for(input string name, input int min_pts, input bit want_req);
        int cyc;
        cyc = 0;
        while (!((got_q.size() >= min_pts) && (!want_req || stb_req)) && (cyc < 5000)) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " reached"}, (cyc < 5000), 64'd1);
    endtask

    initial begin
        int n;
        vecs[0] = '{16'd100,  16'd1,     10'd100,  3,  1'b0, 12,   16'd101};
        vecs[1] = '{16'hFFFF, 16'h4000,  10'd1000, 20, 1'b0, 3,    16'hC000};
        vecs[2] = '{16'h1234, 16'h1000,  10'd512,  2,  1'b1, 3,    16'h2000};
        vecs[3] = '{16'd0,    16'd0,     10'd0,    2,  1'b0, 1024, 16'd1};

        arst = 1'b1; run = 1'b0; td = 16'd0; dd = 10'd0; rdy = 1'b1; stb_valid = 1'b0;
        fill_sig(16'd0);
        repeat (3) @(negedge clk);
        check("reset outputs", {thr, wre, stb_req, dcode, prdy, pv, pt}, 64'd0);
        arst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle outputs", {thr, wre, stb_req, dcode, prdy, pv, pt}, 64'd0);

        for (int k = 0; k < 4; k++) begin
            fill_sig(vecs[k].sig);
            run_sweep($sformatf("vec%0d", k), vecs[k].tdel, vecs[k].ddel, vecs[k].lat, vecs[k].hold, 1'b0);
            check($sformatf("vec%0d table npts", k), got_q.size(), vecs[k].exp_n);
            n = 0;
            for (int i = 0; i < got_q.size(); i++) if (got_q[i].v !== vecs[k].exp_v) n++;
            check($sformatf("vec%0d table v mismatches", k), n, 0);
        end

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 1024; i++) sig_tab[i] = 16'($urandom_range(0, 65535));
            run_sweep($sformatf("rand%0d", r), 16'($urandom_range(16'h0800, 16'h4000)),
                      10'($urandom_range(150, 400)), $urandom_range(2, 6), 1'b0, 1'b1);
        end

        // Abort while a strobe is outstanding, then rerun from code 0.
        fill_sig(16'd40);
        got_q.delete();
        dac_lat = 3; dac_hold = 1'b0; dac_rand = 1'b0;
        td = 16'd10; dd = 10'd100; run = 1'b1;
        wait_for("abort", 2, 1'b1);
        run = 1'b0;
        @(negedge clk);
        check("abort req drop", stb_req, 1'b0);
        check("abort wre", wre, 1'b0);
        check("abort point hold", {pv, pt}, {16'd50, 10'd100});
        n = got_q.size();
        repeat (4) @(negedge clk);
        check("abort stays idle", {stb_req, wre, prdy}, 3'b000);
        check("abort no point", got_q.size(), n);
        run = 1'b1;
        @(negedge clk);
        check("rerun code", dcode, 10'd0);
        check("rerun thr", thr, 16'd0);
        check("rerun wre", wre, 1'b1);

        // Asynchronous reset in the middle of a sweep.
        wait_for("reset mid", n + 1, 1'b0);
        repeat (7) @(negedge clk);
        arst = 1'b1;
        #1;
        check("async reset outputs", {thr, wre, stb_req, dcode, prdy, pv, pt}, 64'd0);
        run = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        n = got_q.size();
        repeat (10) @(negedge clk);
        check("post reset idle", {thr, wre, stb_req, dcode, prdy, pv, pt}, 64'd0);
        check("post reset no point", got_q.size(), n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ch_measure_ctrl.md
Name: ch_measure_ctrl

Overview:
- Per-channel measurement sequencer that reconstructs a repetitive waveform by equivalent-time sampling.
- For each strobe delay code it searches the comparator threshold: program DAC threshold, request one strobe from the strobe generator, sample the latched comparator.
- Emits one (time code, threshold) point per delay code.
- Sits between the channel DAC, delay line/comparator and the strobe generator (stb_gen).

Parameters:
- SETTLE_CYCLES, 4, clk_i cycles waited after stb_valid_i before sampling cmp_out_i.
- TW, 10, delay-code width (d_code_o, point_t_o).
- VW, 16, threshold width (threshold_o, point_v_o).

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  asynchronous reset, active-high.
- run_i  in  1  level; high starts/continues a sweep, low aborts.
- threshold_delta_i  in  16  threshold search step (0 treated as 1).
- d_code_delta_i  in  10  delay-code step (0 treated as 1).
- threshold_o  out  16  threshold value to DAC.
- threshold_wre_o  out  1  one-cycle DAC write pulse.
- threshold_rdy_i  in  1  DAC settled; goes low after a write, high when the new value is applied.
- cmp_out_i  in  1  comparator output, 1 = signal >= threshold at strobe instant.
- stb_req_o  out  1  strobe request to stb_gen.
- stb_valid_i  in  1  stb_gen acknowledges the strobe was fired.
- d_code_o  out  10  current delay-line code.
- point_rdy_o  out  1  one-cycle pulse, point valid.
- point_v_o  out  16  threshold result of point.
- point_t_o  out  10  delay code of point.

Behaviour:
- Reset: all outputs 0, state IDLE.
- IDLE: when run_i = 1, load d_code_o = 0 and threshold_o = 0, then go to WR.
- WR: pulse threshold_wre_o for one cycle with threshold_o stable, then go to WAIT_LO.
- WAIT_LO: wait for threshold_rdy_i = 0, then go to WAIT_HI.
- WAIT_HI: wait for threshold_rdy_i = 1, then go to REQ.
- WAIT_LO timeout: if threshold_rdy_i is still 1 after 16 cycles, proceed to WAIT_HI.
- REQ: stb_req_o = 1, held until stb_valid_i = 1. Drop stb_req_o the cycle after stb_valid_i is seen, then go to SETTLE.
- SETTLE: wait SETTLE_CYCLES, then go to SAMPLE.
- SAMPLE: register cmp_out_i.
  - If 1 and threshold_o + threshold_delta_i <= 16'hFFFF: threshold_o += delta and go to WR.
  - Otherwise (0, or addition would overflow): go to EMIT.
- EMIT: point_v_o = threshold_o, point_t_o = d_code_o, point_rdy_o = 1 for exactly one cycle. Both point values hold until the next EMIT.
- NEXT:
  - If d_code_o == 1023: go to DONE.
  - Else d_code_o = min(d_code_o + d_code_delta_i, 1023), threshold_o = 0, go to WR.
  - The final point therefore always has point_t_o = 1023.
- DONE: outputs hold; return to IDLE when run_i = 0.
- run_i = 0 in any state other than IDLE/DONE: abort to IDLE next cycle; stb_req_o and threshold_wre_o forced 0; point registers hold.
- Arithmetic: the 17-bit threshold sum is used for the overflow check. Saturation emits point_v_o = last in-range threshold.
- d_code_o changes only in NEXT, so the delay line is stable during the entire threshold search.
- stb_valid_i arriving while not in REQ is ignored.

Optional Feature:
- Macro CH_MEASURE_SYNC_EN.
- Defined: cmp_out_i and threshold_rdy_i pass through 2-flop synchronizers before use. This adds 2 cycles latency to both; SETTLE timing counts from the synchronized value.
- Undefined: inputs used directly (caller guarantees clk_i-synchronous inputs).

Test Plan:
- Reset: assert arst_i mid-sweep -> all outputs 0 immediately; IDLE after release; no point_rdy_o.
- DAC handshake: run_i = 1, DAC model drops rdy on wre and raises it 200 ns later.
  - Exactly one wre pulse per threshold.
  - stb_req_o never asserts before rdy returns high.
- Constant signal 100, threshold_delta 1, d_code_delta 1 -> 1024 points.
  - point_v_o = 101 for every point.
  - point_t_o = 0..1023 in order.
  - point_rdy_o is 1 cycle wide; DONE after t = 1023.
- Step 10 with d_code_delta 100 -> point_t_o = 0, 100, ..., 1000, 1023 (12 points), then DONE.
- Comparator always 1 with threshold_delta 16'h4000 -> thresholds 0, 4000, 8000, C000.
  - 4000 is the next step that would overflow, so the search stops at C000.
  - point_v_o = 16'hC000.
- Abort: drop run_i while in REQ -> stb_req_o = 0 next cycle, state IDLE; rerun restarts at d_code_o = 0.
